// File: rtl/encoder_round_ctrl.sv
// Encoder round sequencer: ColParity/Rotate/Permute/Revaluate start handshakes, AddRC load, round count.
// Optional per-step watchdog built only when ENC_TIMEOUT_EN is defined.
module encoder_round_ctrl #(
  parameter int NUM_TURNS = 24,
  parameter int TURN_BITS = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           step_done,
  output logic [3:0]           step_start,
  output logic                 state_ld,
  output logic                 sel_feedback,
  output logic [TURN_BITS-1:0] turn,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  // state | meaning
  // IDLE  | waiting for an accepted start
  // CP    | ColParity running, wait step_done[0]
  // ROT   | Rotate running, wait step_done[1]
  // PERM  | Permute running, wait step_done[2]
  // REV   | Revaluate running, wait step_done[3]
  // ARC   | load AddRC result, advance or finish round
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, CP, ROT, PERM, REV, ARC, DONE} state_t;

  localparam logic [TURN_BITS-1:0] LAST_TURN = TURN_BITS'(NUM_TURNS - 1);

  state_t               state_q, state_d;
  logic [TURN_BITS-1:0] turn_q, turn_d;
  logic                 first_q;
  logic                 in_step;
  logic [1:0]           step_idx;
  logic                 step_ack;
  logic                 start_ok;
  logic                 wd_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      turn_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      first_q <= (state_d != state_q);
    end
  end

  always_comb begin
    in_step  = 1'b1;
    step_idx = 2'd0;
    case (state_q)
      CP:      step_idx = 2'd0;
      ROT:     step_idx = 2'd1;
      PERM:    step_idx = 2'd2;
      REV:     step_idx = 2'd3;
      default: in_step  = 1'b0;
    endcase
  end

  // A done in the same cycle as its start pulse is not an answer.
  assign step_ack = in_step && !first_q && step_done[step_idx];
  assign start_ok = (state_q == IDLE) && start && !abort;

  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = CP;
          turn_d  = '0;
        end
      end
      CP:   if (step_ack) state_d = ROT;
      ROT:  if (step_ack) state_d = PERM;
      PERM: if (step_ack) state_d = REV;
      REV:  if (step_ack) state_d = ARC;
      ARC: begin
        if (turn_q == LAST_TURN) begin
          state_d = DONE;
        end else begin
          state_d = CP;
          turn_d  = turn_q + TURN_BITS'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wd_expired) state_d = IDLE;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      turn_d  = '0;
    end
  end

  always_comb begin
    step_start = 4'b0000;
    if (in_step && first_q) step_start[step_idx] = 1'b1;
    state_ld     = (state_q == ARC);
    done         = (state_q == DONE);
    busy         = (state_q != IDLE);
    sel_feedback = (state_q != IDLE) && (turn_q != '0);
    turn         = turn_q;
  end

`ifdef ENC_TIMEOUT_EN
  localparam int WD_BITS = $clog2(TIMEOUT + 1);

  logic [WD_BITS-1:0] wd_q;
  logic               error_q;

  // Loaded in the start-pulse cycle so terminal count lands TIMEOUT cycles after the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      if (in_step && first_q) wd_q <= WD_BITS'(TIMEOUT - 2);
      else if (in_step && (wd_q != '0)) wd_q <= wd_q - WD_BITS'(1);
      if (start_ok) error_q <= 1'b0;
      else if (wd_expired) error_q <= 1'b1;
    end
  end

  assign wd_expired = in_step && !first_q && (wd_q == '0) && !step_ack && !abort;
  assign error      = error_q;
`else
  if (TIMEOUT < 2) begin : g_timeout_short
  end
  assign wd_expired = 1'b0;
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_round_ctrl.sv
// Bench for encoder_round_ctrl: timeline model built from step latencies, table runs, random runs, corner sequences.
module tb_encoder_round_ctrl;
  localparam int NT   = 24;
  localparam int TMO  = 64;
  localparam int MAXC = 2048;

  logic       clk, rst, start, abort;
  logic [3:0] step_done, step_start;
  logic       state_ld, sel_feedback, busy, done, error;
  logic [4:0] turn;

  encoder_round_ctrl #(.NUM_TURNS(NT), .TURN_BITS(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step_done(step_done),
    .step_start(step_start), .state_ld(state_ld), .sel_feedback(sel_feedback),
    .turn(turn), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int l0; int l1; int l2; int l3;
    int exp_done;
    int exp_gap;
  } vec_t;

  int errors = 0;
  int checks = 0;

  int         lat    [NT][4];
  logic [3:0] e_ss   [MAXC];
  logic [3:0] e_fire [MAXC];
  logic       e_ld   [MAXC];
  logic       e_busy [MAXC];
  logic       e_done [MAXC];
  logic [4:0] e_turn [MAXC];
  int         e_step [MAXC];
  logic       err_lvl;
  int         meas_done, meas_ld, gap_min, gap_max;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int e);
    for (int r = 0; r < NT; r++) begin
      lat[r][0] = a; lat[r][1] = b; lat[r][2] = c; lat[r][3] = e;
    end
  endtask

  // Timeline: each step lasts its latency + 1 cycles, each round ends with one ARC cycle.
  task automatic build_model(output int d);
    int t;
    for (int c = 0; c < MAXC; c++) begin
      e_ss[c] = '0; e_fire[c] = '0; e_ld[c] = 1'b0; e_busy[c] = 1'b0;
      e_done[c] = 1'b0; e_turn[c] = '0; e_step[c] = -1;
    end
    t = 1;
    for (int r = 0; r < NT; r++) begin
      for (int i = 0; i < 4; i++) begin
        e_ss[t][i] = 1'b1;
        e_fire[t + lat[r][i]][i] = 1'b1;
        for (int k = 0; k <= lat[r][i]; k++) begin
          e_busy[t + k] = 1'b1;
          e_turn[t + k] = 5'(r);
          e_step[t + k] = i;
        end
        t += lat[r][i] + 1;
      end
      e_busy[t] = 1'b1; e_ld[t] = 1'b1; e_turn[t] = 5'(r);
      t++;
    end
    e_busy[t] = 1'b1; e_done[t] = 1'b1; e_turn[t] = 5'(NT - 1);
    d = t;
  endtask

  task automatic run_encode(input bit spur, input bit hold, input int kill_at, input bit kill_rst, output int d);
    int          last, prev_ld;
    logic [3:0]  cur;
    logic [13:0] act, exp;
    bit          idle_k;
    build_model(d);
    last = (kill_at >= 0) ? kill_at + 2 : (hold ? d + 2 : d + 1);
    meas_done = -1; meas_ld = 0; gap_min = MAXC; gap_max = 0; prev_ld = -1;
    for (int c = 0; c <= last; c++) begin
      idle_k = (kill_at >= 0) && (kill_rst ? (c >= kill_at) : (c > kill_at));
      cur = (e_step[c] >= 0) ? 4'(1 << e_step[c]) : 4'b0000;
      start = (c == 0) || hold || (spur && c <= d && $urandom_range(0, 3) == 0);
      abort = (kill_at >= 0) && !kill_rst && (c == kill_at);
      step_done = idle_k ? 4'b0000 : e_fire[c];
      if (spur) step_done = step_done | e_ss[c] | (4'($urandom()) & ~cur);
      if (kill_rst && c == kill_at) rst = 1'b0;
      if (kill_rst && c == kill_at + 2) rst = 1'b1;
      @(negedge clk);
      act = {step_start, state_ld, sel_feedback, turn, busy, done, error};
      if (idle_k) begin
        exp = '0;
      end else if (hold && c == d + 2) begin
        exp = {4'b0001, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
      end else begin
        exp = {e_ss[c], e_ld[c], e_busy[c] && (e_turn[c] != 5'd0), e_turn[c], e_busy[c], e_done[c],
               (c == 0) ? err_lvl : 1'b0};
        if (!e_busy[c]) act[7:3] = 5'd0;  // turn left undefined while idle after completion
      end
      check("trace", c, 32'(act), 32'(exp));
      if (done && meas_done < 0) meas_done = c;
      if (state_ld) begin
        meas_ld++;
        if (prev_ld >= 0) begin
          if (c - prev_ld < gap_min) gap_min = c - prev_ld;
          if (c - prev_ld > gap_max) gap_max = c - prev_ld;
        end
        prev_ld = c;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; step_done = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 0, 32'({step_start, state_ld, sel_feedback, turn, busy, done, error}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tab [4];
    int   d;
    tab[0] = '{1, 1, 1, 1, 217, 9};
    tab[1] = '{2, 2, 2, 2, 313, 13};
    tab[2] = '{1, 2, 3, 4, 361, 15};
    tab[3] = '{10, 1, 10, 1, 649, 27};

    rst = 1'b0; start = 1'b0; abort = 1'b0; step_done = '0; err_lvl = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", 0, 32'({step_start, state_ld, sel_feedback, turn, busy, done, error}), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      set_lat(tab[v].l0, tab[v].l1, tab[v].l2, tab[v].l3);
      run_encode(1'b0, 1'b0, -1, 1'b0, d);
      check("table_done_cycle", v, 32'(meas_done), 32'(tab[v].exp_done));
      check("table_ld_count", v, 32'(meas_ld), 32'(NT));
      check("table_ld_gap_min", v, 32'(gap_min), 32'(tab[v].exp_gap));
      check("table_ld_gap_max", v, 32'(gap_max), 32'(tab[v].exp_gap));
    end

    for (int n = 0; n < 3; n++) begin
      for (int r = 0; r < NT; r++)
        for (int i = 0; i < 4; i++) lat[r][i] = $urandom_range(1, 10);
      run_encode(1'b1, 1'b0, -1, 1'b0, d);
      check("rand_done_cycle", n, 32'(meas_done), 32'(d));
      check("rand_ld_count", n, 32'(meas_ld), 32'(NT));
    end

    set_lat(1, 1, 1, 1);
    run_encode(1'b0, 1'b0, 50, 1'b0, d);
    check("abort_no_done", 50, 32'(meas_done), 32'hFFFF_FFFF);
    for (int c = 53; c <= 54; c++) begin
      @(negedge clk);
      check("abort_idle", c, 32'({busy, done, turn}), 32'd0);
      @(posedge clk); #1;
    end
    run_encode(1'b0, 1'b0, -1, 1'b0, d);
    check("abort_restart_done", 55, 32'(meas_done), 32'd217);

    run_encode(1'b0, 1'b1, -1, 1'b0, d);
    check("hold_start_done", 0, 32'(meas_done), 32'd217);
    do_reset();

    run_encode(1'b0, 1'b0, 95, 1'b1, d);
    check("reset_no_done", 95, 32'(meas_done), 32'hFFFF_FFFF);
    run_encode(1'b0, 1'b0, -1, 1'b0, d);
    check("reset_restart_done", 0, 32'(meas_done), 32'd217);

    for (int c = 0; c <= 100; c++) begin
      start = (c == 0);
      step_done = (c == 2) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      if (c == 3) check("wd_rot_pulse", c, 32'(step_start), 32'h2);
`ifdef ENC_TIMEOUT_EN
      if (c == 66) check("wd_busy_before", c, 32'({busy, error}), 32'b10);
      if (c == 67 || c == 100) check("wd_idle_error", c, 32'({busy, done, error}), 32'b001);
`else
      if (c == 67 || c == 100) check("wd_off_wait", c, 32'({busy, step_start, error}), 32'b1_0000_0);
`endif
      @(posedge clk); #1;
    end
    step_done = '0;
`ifdef ENC_TIMEOUT_EN
    err_lvl = 1'b1;
    run_encode(1'b0, 1'b0, -1, 1'b0, d);
    err_lvl = 1'b0;
    check("wd_recover_done", 0, 32'(meas_done), 32'd217);
`else
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/encoder_round_ctrl.md
# encoder_round_ctrl

Centralised sequencer for the encoder round datapath. It replaces the chained done-to-start wiring between ColParity, Rotate, Permute, Revaluate and AddRC with a single FSM. The FSM issues one-hot step start pulses, waits for each unit's done, and owns the round counter, the input-select mux control and the state-register load. It sits between the top-level encoder wrapper (start/done/abort) and the four step units plus the AddRC/state register.

## Interface
- NUM_TURNS, 24, number of rounds per encode
- TURN_BITS, 5, width of round index (must hold NUM_TURNS-1)
- TIMEOUT, 64, max cycles from a step start pulse to its done (used only with watchdog)
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request one encode; sampled only in IDLE
- abort  input  1  cancel the current encode; return to IDLE
- step_done  input  4  done pulses: [0] ColParity, [1] Rotate, [2] Permute, [3] Revaluate
- step_start  output  4  one-cycle start pulses, same bit order
- state_ld  output  1  load AddRC output into the state register
- sel_feedback  output  1  0: ColParity takes external data_in; 1: takes the state register
- turn  output  TURN_BITS  current round index, drives AddRC round-constant select
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on encode completion
- error  output  1  sticky watchdog flag (see Configuration)

## Operation
- States: IDLE, CP, ROT, PERM, REV, ARC, DONE.
- IDLE: start=1 and abort=0 → CP, turn←0, error←0.
- CP/ROT/PERM/REV (step i = 0..3): step_start[i]=1 only in the first cycle of the state. When step_done[i] is sampled high → next state (CP→ROT→PERM→REV→ARC). step_done bits of non-current steps are ignored.
- ARC: single cycle, state_ld=1.
  - If turn==NUM_TURNS-1 → DONE.
  - Else turn←turn+1 and → CP.
- DONE: single cycle, done=1, turn holds NUM_TURNS-1 → IDLE. start during DONE is ignored.
- sel_feedback = (turn != 0) in all non-IDLE states; 0 in IDLE.
- abort=1 in any non-IDLE state → IDLE next cycle. It forces turn←0 and suppresses done and state_ld. abort overrides start and step_done in the same cycle.
- turn never wraps: the increment happens only in ARC with turn < NUM_TURNS-1.

## Timing
- Reset values: state IDLE; step_start=0, state_ld=0, sel_feedback=0, turn=0, busy=0, done=0, error=0. All outputs are registered or decoded from registered state, with no input-to-output combinational paths.
- Reset is asynchronous. Assertion mid-encode aborts immediately, with no done pulse.
- Let L_i be the cycle count from a step_start[i] pulse to its step_done[i] (L_i ≥ 1).
  - Each step occupies L_i+1 cycles.
  - One round takes Σ(L_i+1)+1 cycles.
- Timeline with start sampled at cycle 0:
  - CP is entered at cycle 1.
  - done is high at cycle 1 + NUM_TURNS·(Σ(L_i+1)+1).
  - busy falls the cycle after done.
- A step_done arriving in the same cycle as step_start (L_i=0) is ignored. The unit must answer at least one cycle later.

## Configuration
- ENC_TIMEOUT_EN defined: a per-step watchdog counter clears on each step_start pulse. If step_done[i] has not been seen after TIMEOUT cycles in a step state, the FSM goes to IDLE with no done pulse, and error is set. error stays high until the next accepted start clears it.
- ENC_TIMEOUT_EN undefined: no watchdog logic. The FSM waits indefinitely in a step state. The error port is present and tied to 0.

## Test plan
- Nominal: stub units with L_i=1, NUM_TURNS=24, start at cycle 0 → expected response:
  - done pulse at cycle 217.
  - 24 state_ld pulses, spaced 9 cycles apart.
  - turn steps 0..23.
  - sel_feedback=0 only during round 0.
- Handshake ordering: random L_i in 1..10 per step, spurious step_done on non-current bits → step_start order CP,ROT,PERM,REV every round, spurious dones ignored, done at the computed cycle.
- Abort: abort at cycle 50 of a nominal run → IDLE at cycle 51, busy=0, turn=0, no done; a new start at cycle 55 completes normally at cycle 55+217.
- Busy/start collision: start held high continuously → after each done, one IDLE cycle, then a new encode; start during DONE does not shorten that IDLE cycle.
- Async reset: rst low for 2 cycles mid-round 10 → all outputs 0 within the reset cycle; the next start gives a full 217-cycle encode.
- Watchdog (ENC_TIMEOUT_EN, TIMEOUT=64): Rotate never answers → IDLE and error=1, 64 cycles after the ROT start pulse; error clears on the next accepted start. Without the macro → FSM stays in ROT and error=0.
